// File: rtl/cdb_scheduler_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : cdb_scheduler_pkg                                             |
// | Description : Shared definitions for common-data-bus scheduling. Holds the  |
// |               idle select code, the bus count and the arbiter address type  |
// |               used by the scheduler and by the combo arbiters.              |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
package cdb_scheduler_pkg;

   // Select code a bus shows when nobody is driving it. No combo may use it.
   localparam logic [7:0] IDLE_SELECT = 8'hFF;

   // Number of common data buses in this revision.
   localparam int CDB_COUNT = 2;

   // Arbiter address broadcast on a bus select line.
   typedef logic [7:0] arb_addr_t;

endpackage : cdb_scheduler_pkg
`default_nettype wire

// File: rtl/cdb_scheduler_rr_pick.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : cdb_scheduler_rr_pick                                         |
// | Description : Combinational circular find-first-set. Scans req starting at  |
// |               bit 'start' and wrapping modulo WIDTH; reports whether any    |
// |               bit is set and the index of the first one found.              |
// | Ports       : req   - request vector                                        |
// |               start - scan start index (must be < WIDTH)                    |
// |               valid - at least one request bit set                          |
// |               index - first set bit at or after start, circularly           |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module cdb_scheduler_rr_pick #(
   parameter int WIDTH = 4,
   parameter int IDXW  = 2
) (
   input  logic [WIDTH-1:0] req,
   input  logic [IDXW-1:0]  start,
   output logic             valid,
   output logic [IDXW-1:0]  index
);

   int                w_pos;
   logic [IDXW-1:0]   w_k;

   // Scan offsets from the far end back to zero so that the smallest offset
   // (the one closest to start) is the last to write the result and wins.
   always_comb begin
      valid = 1'b0;
      index = '0;
      w_pos = 0;
      w_k   = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         w_pos = int'(start) + i;
         if (w_pos >= WIDTH) begin
            w_pos = w_pos - WIDTH;
         end
         w_k = IDXW'(w_pos);
         if (req[w_k]) begin
            valid = 1'b1;
            index = w_k;
         end
      end
   end

endmodule : cdb_scheduler_rr_pick
`default_nettype wire

// File: rtl/cdb_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : cdb_scheduler                                                 |
// | Description : Round-robin scheduler for the two common data buses. Picks up |
// |               to two requesting combos per cycle and broadcasts each        |
// |               winner's arbiter address on the per-bus select lines.         |
// | Ports       : clock      - system clock, rising edge                        |
// |               reset      - asynchronous active-low reset                    |
// |               get_bus    - per-combo bus request                            |
// |               bus_enable - per-bus grant permission                         |
// |               select     - per-bus selected arbiter address (registered)    |
// |               grant      - per-combo grant, high while on a bus (registered)|
// |               busy       - any bus carries a selection (registered)         |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module cdb_scheduler
   import cdb_scheduler_pkg::*;
#(
   parameter int                         REQUESTERS = 4,
   parameter int                         BUSES      = CDB_COUNT,
   parameter logic [REQUESTERS-1:0][7:0] ADDRESSES  = {8'h03, 8'h02, 8'h01, 8'h00}
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [REQUESTERS-1:0]    get_bus,
   input  logic [BUSES-1:0]         bus_enable,
   output logic [BUSES-1:0][7:0]    select,
   output logic [REQUESTERS-1:0]    grant,
   output logic                     busy
);

   localparam int                    IDXW       = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
   localparam logic [IDXW-1:0]       c_last_idx = IDXW'(REQUESTERS - 1);
   localparam logic [REQUESTERS-1:0] c_one      = REQUESTERS'(1);

   logic [IDXW-1:0]           r_ptr;
   logic [REQUESTERS-1:0]     r_grant;
   logic [BUSES-1:0][7:0]     r_select;
   logic                      r_busy;

   logic [REQUESTERS-1:0]     w_eligible;
   logic [REQUESTERS-1:0]     w_elig1;
   logic                      w_w0_valid;
   logic [IDXW-1:0]           w_w0_idx;
   logic [IDXW-1:0]           w_w0_next;
   logic                      w_w1_valid;
   logic [IDXW-1:0]           w_w1_idx;
   logic                      w_w0_on;
   logic                      w_w1_on;
   logic [IDXW-1:0]           w_last_idx;
   logic [BUSES-1:0][7:0]     w_sel_next;
   logic [REQUESTERS-1:0]     w_grant_next;
   logic [IDXW-1:0]           w_ptr_next;

   function automatic logic [IDXW-1:0] f_inc(input logic [IDXW-1:0] idx);
      return (idx == c_last_idx) ? '0 : idx + 1'b1;
   endfunction

   // A combo currently shown on a bus still has its request high this cycle;
   // masking it out prevents a duplicate grant for the same result.
   assign w_eligible = get_bus & ~r_grant;
   assign w_w0_next  = f_inc(w_w0_idx);
   assign w_elig1    = w_eligible & ~(c_one << w_w0_idx);

   cdb_scheduler_rr_pick #(
      .WIDTH (REQUESTERS),
      .IDXW  (IDXW)
   ) u_pick0 (
      .req   (w_eligible),
      .start (r_ptr),
      .valid (w_w0_valid),
      .index (w_w0_idx)
   );

   cdb_scheduler_rr_pick #(
      .WIDTH (REQUESTERS),
      .IDXW  (IDXW)
   ) u_pick1 (
      .req   (w_elig1),
      .start (w_w0_next),
      .valid (w_w1_valid),
      .index (w_w1_idx)
   );

   // Winners fill the enabled buses in ascending bus order: the first winner
   // always takes the lowest enabled bus, the second only when both are open.
   always_comb begin
      w_sel_next   = {BUSES{IDLE_SELECT}};
      w_grant_next = '0;
      w_ptr_next   = r_ptr;
      w_w0_on      = 1'b0;
      w_w1_on      = 1'b0;
      case (bus_enable[1:0])
         2'b11: begin
            w_w0_on = w_w0_valid;
            w_w1_on = w_w1_valid;
            if (w_w0_valid) w_sel_next[0] = ADDRESSES[w_w0_idx];
            if (w_w1_valid) w_sel_next[1] = ADDRESSES[w_w1_idx];
         end
         2'b01: begin
            w_w0_on = w_w0_valid;
            if (w_w0_valid) w_sel_next[0] = ADDRESSES[w_w0_idx];
         end
         2'b10: begin
            w_w0_on = w_w0_valid;
            if (w_w0_valid) w_sel_next[1] = ADDRESSES[w_w0_idx];
         end
         default: ;
      endcase
      if (w_w0_on) w_grant_next = w_grant_next | (c_one << w_w0_idx);
      if (w_w1_on) w_grant_next = w_grant_next | (c_one << w_w1_idx);
      // The pointer moves past the last requester granted this cycle.
      w_last_idx = w_w1_on ? w_w1_idx : w_w0_idx;
      if (w_w0_on) w_ptr_next = f_inc(w_last_idx);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_ptr    <= '0;
         r_grant  <= '0;
         r_select <= {BUSES{IDLE_SELECT}};
         r_busy   <= 1'b0;
      end else begin
         r_ptr    <= w_ptr_next;
         r_grant  <= w_grant_next;
         r_select <= w_sel_next;
         r_busy   <= w_w0_on;
      end
   end

   assign select = r_select;
   assign grant  = r_grant;
   assign busy   = r_busy;

endmodule : cdb_scheduler
`default_nettype wire

// File: tb/tb_cdb_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_cdb_scheduler                                              |
// | Description : Self-checking bench for cdb_scheduler. A queue-based          |
// |               round-robin reference model predicts select/grant/busy every  |
// |               cycle; directed sequences pin the model with literal values.  |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_cdb_scheduler;

   localparam int N = 4;

   logic              clock;
   logic              reset;
   logic [N-1:0]      get_bus;
   logic [1:0]        bus_enable;
   logic [1:0][7:0]   select;
   logic [N-1:0]      grant;
   logic              busy;

   logic [7:0]        addr_tab [N] = '{8'h00, 8'h01, 8'h02, 8'h03};

   // reference model state
   logic [7:0]        m_sel [2];
   logic [N-1:0]      m_grant;
   logic              m_busy;
   int                m_ptr;

   int                n_vec;
   int                n_err;
   logic              cmp_en;

   cdb_scheduler u_dut (
      .clock      (clock),
      .reset      (reset),
      .get_bus    (get_bus),
      .bus_enable (bus_enable),
      .select     (select),
      .grant      (grant),
      .busy       (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: list eligible requesters in circular order from the pointer,
   // list enabled buses in ascending order, and pair them off.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_sel[0] <= 8'hFF;
         m_sel[1] <= 8'hFF;
         m_grant  <= '0;
         m_busy   <= 1'b0;
         m_ptr    <= 0;
      end else begin
         int           cand [$];
         int           buses [$];
         int           n;
         logic [7:0]   ns [2];
         logic [N-1:0] ng;
         int           np;
         cand  = {};
         buses = {};
         for (int off = 0; off < N; off++) begin
            int idx;
            idx = (m_ptr + off) % N;
            if (get_bus[idx] && !m_grant[idx]) cand.push_back(idx);
         end
         for (int b = 0; b < 2; b++) if (bus_enable[b]) buses.push_back(b);
         n     = (cand.size() < buses.size()) ? cand.size() : buses.size();
         ns[0] = 8'hFF;
         ns[1] = 8'hFF;
         ng    = '0;
         np    = m_ptr;
         for (int k = 0; k < n; k++) begin
            ns[buses[k]] = addr_tab[cand[k]];
            ng[cand[k]]  = 1'b1;
         end
         if (n > 0) np = (cand[n-1] + 1) % N;
         m_sel[0] <= ns[0];
         m_sel[1] <= ns[1];
         m_grant  <= ng;
         m_busy   <= (n > 0);
         m_ptr    <= np;
      end
   end

   always @(negedge clock) begin
      if (cmp_en) begin
         chk("model_sel0",  32'(select[0]), 32'(m_sel[0]));
         chk("model_sel1",  32'(select[1]), 32'(m_sel[1]));
         chk("model_grant", 32'(grant),     32'(m_grant));
         chk("model_busy",  32'(busy),      32'(m_busy));
      end
   end

   task automatic step(input logic [N-1:0] gb, input logic [1:0] be);
      get_bus    = gb;
      bus_enable = be;
      @(negedge clock);
   endtask

   task automatic expect_out(input string name, input logic [7:0] s0, input logic [7:0] s1,
                             input logic [N-1:0] g, input logic b);
      chk({name, "_sel0"},  32'(select[0]), 32'(s0));
      chk({name, "_sel1"},  32'(select[1]), 32'(s1));
      chk({name, "_grant"}, 32'(grant),     32'(g));
      chk({name, "_busy"},  32'(busy),      32'(b));
   endtask

   initial begin
      n_vec      = 0;
      n_err      = 0;
      cmp_en     = 1'b0;
      reset      = 1'b0;
      get_bus    = 4'b1111;
      bus_enable = 2'b11;

      // reset held with all requests high
      @(negedge clock);
      cmp_en = 1'b1;
      repeat (2) @(negedge clock);
      expect_out("reset", 8'hFF, 8'hFF, 4'b0000, 1'b0);
      reset = 1'b1;

      // saturation: pairs {0,1},{2,3},{0,1},{2,3}
      step(4'b1111, 2'b11);
      expect_out("sat0", 8'h00, 8'h01, 4'b0011, 1'b1);
      step(4'b1111, 2'b11);
      expect_out("sat1", 8'h02, 8'h03, 4'b1100, 1'b1);
      step(4'b1111, 2'b11);
      expect_out("sat2", 8'h00, 8'h01, 4'b0011, 1'b1);
      step(4'b1111, 2'b11);
      expect_out("sat3", 8'h02, 8'h03, 4'b1100, 1'b1);

      // single request, then masked while still high
      step(4'b0000, 2'b11);
      expect_out("idle", 8'hFF, 8'hFF, 4'b0000, 1'b0);
      step(4'b0100, 2'b11);
      expect_out("single", 8'h02, 8'hFF, 4'b0100, 1'b1);
      step(4'b0100, 2'b11);
      expect_out("masked", 8'hFF, 8'hFF, 4'b0000, 1'b0);

      // wrap: ptr=3, requesters 3 and 0
      step(4'b1001, 2'b11);
      expect_out("wrap", 8'h03, 8'h00, 4'b1001, 1'b1);

      // move pointer to 2, then only bus1 enabled
      step(4'b0010, 2'b11);
      expect_out("ptr_move", 8'h01, 8'hFF, 4'b0010, 1'b1);
      step(4'b0000, 2'b11);
      step(4'b0011, 2'b10);
      expect_out("bus1_only_a", 8'hFF, 8'h00, 4'b0001, 1'b1);
      step(4'b0011, 2'b10);
      expect_out("bus1_only_b", 8'hFF, 8'h01, 4'b0010, 1'b1);

      // mid-operation asynchronous reset
      step(4'b0000, 2'b11);
      step(4'b1100, 2'b11);
      expect_out("pre_reset", 8'h02, 8'h03, 4'b1100, 1'b1);
      #2 reset = 1'b0;
      #1 expect_out("async_reset", 8'hFF, 8'hFF, 4'b0000, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      step(4'b1111, 2'b11);
      expect_out("after_reset", 8'h00, 8'h01, 4'b0011, 1'b1);

      // randomized traffic: requests held until granted, occasional drops
      for (int c = 0; c < 3000; c++) begin
         logic [N-1:0] nxt;
         int           r;
         logic [1:0]   be;
         for (int i = 0; i < N; i++) begin
            if (get_bus[i] && !m_grant[i]) nxt[i] = ($urandom_range(0, 19) != 0);
            else                           nxt[i] = ($urandom_range(0, 2) == 0);
         end
         if ($urandom_range(0, 15) == 0) nxt = '1;
         r  = $urandom_range(0, 7);
         be = (r < 5) ? 2'b11 : (r == 5) ? 2'b01 : (r == 6) ? 2'b10 : 2'b00;
         step(nxt, be);
      end

      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_cdb_scheduler
`default_nettype wire
